// File: rtl/filter_dt_if.sv
// rtl/filter_dt_if.sv - block-in / byte-out handshake bundle for the filter_dt serializer
interface filter_dt_if #(
  parameter int DATA_W = 8,
  parameter int N_ELEM = 9
);
  logic [DATA_W*N_ELEM-1:0] arr_in;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        data_out;
  logic                     data_valid;
  logic                     data_ready;
  logic                     last;

  // Producer of blocks and consumer of bytes
  modport master (
    output arr_in, in_valid, data_ready,
    input  in_ready, data_out, data_valid, last
  );

  // The serializer itself
  modport slave (
    input  arr_in, in_valid, data_ready,
    output in_ready, data_out, data_valid, last
  );
endinterface

// File: rtl/filter_dt.sv
// rtl/filter_dt.sv - serializes one block of N_ELEM elements into sequential bytes, element 0 first
module filter_dt #(
  parameter int DATA_W = 8,
  parameter int N_ELEM = 9
) (
  input  logic        clk,
  input  logic        rst,
  filter_dt_if.slave  bus
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_SEND   = 1'b1;
  localparam logic [3:0] LAST_CNT = 4'(N_ELEM - 1);

  logic [0:0]               r_state;
  logic [DATA_W*N_ELEM-1:0] r_sh;
  logic [3:0]               r_cnt;

  logic w_data_valid;
  logic w_last;
  logic w_in_ready;
  logic w_accept;
  logic w_xfer;

  assign w_data_valid = (r_state == S_SEND);
  assign w_last       = w_data_valid && (r_cnt == LAST_CNT);
  // A new block may enter while idle or on the edge the final byte leaves
  assign w_in_ready   = !w_data_valid || (w_last && bus.data_ready);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_xfer       = w_data_valid && bus.data_ready;

  // Load, shift or drain the block; holds everything while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_sh    <= bus.arr_in;
      r_cnt   <= '0;
      r_state <= S_SEND;
    end else if (w_last && bus.data_ready) begin
      r_sh    <= r_sh >> DATA_W;
      r_cnt   <= '0;
      r_state <= S_IDLE;
    end else if (w_xfer) begin
      r_sh    <= r_sh >> DATA_W;
      r_cnt   <= r_cnt + 4'd1;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.data_out   = r_sh[DATA_W-1:0];
  assign bus.data_valid = w_data_valid;
  assign bus.last       = w_last;

endmodule

// File: tb/tb_filter_dt.sv
// tb/tb_filter_dt.sv - scoreboard bench for filter_dt with directed and random traffic
module tb_filter_dt;
  localparam int DW = 8;
  localparam int NE = 9;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  filter_dt_if #(.DATA_W(DW), .N_ELEM(NE)) bus ();

  filter_dt #(.DATA_W(DW), .N_ELEM(NE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];
  bit accepted_now = 1'b0;
  int vcnt = 0;
  int rcnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference: a block becomes N_ELEM bytes, lowest element first, last flag on the final one
  function automatic void push_block(logic [DW*NE-1:0] blk);
    for (int i = 0; i < NE; i++)
      exp_q.push_back({(i == NE - 1), blk[i*DW +: DW]});
  endfunction

  // One clock of stimulus, driven on the falling edge
  task automatic cycle(input logic v, input logic [DW*NE-1:0] a, input logic r, output logic acc);
    @(negedge clk);
    bus.in_valid   = v;
    bus.arr_in     = a;
    bus.data_ready = r;
    #1;
    acc = 1'b0;
    accepted_now = 1'b0;
    if (!rst) begin
      chk("in_ready", {31'd0, bus.in_ready},
          {31'd0, (exp_q.size() == 0) || (exp_q.size() == 1 && r)});
      if (bus.data_valid) vcnt++;
      if (v && bus.in_ready) begin
        rcnt++;
        acc = 1'b1;
        accepted_now = (exp_q.size() == 0);
        push_block(a);
      end
    end
  endtask

  // Monitor: compares every presented byte against the head of the scoreboard
  logic [DW:0] fr;
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (bus.data_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", bus.data_out);
        end else begin
          fr = exp_q[0];
          chk("data_out", {24'd0, bus.data_out}, {24'd0, fr[DW-1:0]});
          chk("last", {31'd0, bus.last}, {31'd0, fr[DW]});
          if (bus.data_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_last", {31'd0, bus.last}, 32'd0);
        chk("idle_pending", exp_q.size(), accepted_now ? NE : 0);
      end
    end
  end

  logic acc;
  logic have;
  logic [DW*NE-1:0] blk_a;
  logic [DW*NE-1:0] blk_b;
  logic [DW*NE-1:0] blk;
  logic [95:0] rnd;
  int n;

  initial begin
    blk_a = 72'h090807060504030201;
    blk_b = 72'h1211100F0E0D0C0B0A;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.arr_in = '0;
    bus.data_ready = 1'b0;

    cycle(1'b0, '0, 1'b1, acc);
    chk("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
    chk("rst_last", {31'd0, bus.last}, 32'd0);
    chk("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    cycle(1'b0, '0, 1'b1, acc);
    rst = 1'b0;

    // Single block, pulsed valid, arr_in scrambled right after accept
    cycle(1'b1, blk_a, 1'b1, acc);
    chk("t1_accept", {31'd0, acc}, 32'd1);
    repeat (12) cycle(1'b0, ~blk_a, 1'b1, acc);

    // Two blocks back to back with no bubble
    vcnt = 0;
    rcnt = 0;
    cycle(1'b1, blk_a, 1'b1, acc);
    n = 0;
    do begin
      cycle(1'b1, blk_b, 1'b1, acc);
      n++;
    end while (!acc && n < 40);
    chk("t2_b_accept_cycle", n, 9);
    chk("t2_in_ready_with_valid", rcnt, 2);
    repeat (12) cycle(1'b0, '0, 1'b1, acc);
    chk("t2_valid_cycles", vcnt, 18);

    // Consumer stalls every other cycle
    cycle(1'b1, blk_a, 1'b1, acc);
    for (int i = 0; i < 24; i++) cycle(1'b0, blk_b, (i % 2) == 0, acc);
    chk("t3_drain", exp_q.size(), 0);

    // Valid asserted mid-block must wait for the final byte
    cycle(1'b1, blk_a, 1'b1, acc);
    cycle(1'b0, '0, 1'b1, acc);
    cycle(1'b0, '0, 1'b1, acc);
    n = 0;
    do begin
      cycle(1'b1, blk_b, 1'b1, acc);
      n++;
    end while (!acc && n < 40);
    chk("t4_b_accept_cycle", n, 7);
    repeat (12) cycle(1'b0, '0, 1'b1, acc);

    // Asynchronous reset while byte 04 is on the output
    cycle(1'b1, blk_a, 1'b1, acc);
    repeat (3) cycle(1'b0, '0, 1'b1, acc);
    cycle(1'b0, '0, 1'b0, acc);
    chk("t5_pre_reset_byte", {24'd0, bus.data_out}, 32'h04);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
    chk("t5_rst_last", {31'd0, bus.last}, 32'd0);
    chk("t5_rst_data_out", {24'd0, bus.data_out}, 32'd0);
    chk("t5_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    exp_q.delete();
    repeat (2) cycle(1'b0, '0, 1'b1, acc);
    rst = 1'b0;
    vcnt = 0;
    repeat (12) cycle(1'b0, '0, 1'b1, acc);
    chk("t5_no_bytes_after_reset", vcnt, 0);

    // Random traffic: producer holds each block until accepted
    have = 1'b0;
    blk = '0;
    for (int c = 0; c < 3000; c++) begin
      rnd = {$urandom, $urandom, $urandom};
      if (!have && $urandom_range(0, 1) == 1) begin
        blk = rnd[DW*NE-1:0];
        have = 1'b1;
      end
      cycle(have, have ? blk : ~rnd[DW*NE-1:0], $urandom_range(0, 3) != 0, acc);
      if (acc) have = 1'b0;
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cycle(1'b0, '0, 1'b1, acc);
      n++;
    end
    cycle(1'b0, '0, 1'b1, acc);
    chk("final_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
